hilo_unit: RTL
==============

Name: hilo_unit

Overview:
- Consumer side of the ALU's 64-bit result pair (Hi word, Lo word).
- Holds the architectural HI/LO registers and commits MULT, MADD, MSUB, MTHI and MTLO from the EX stage.
- Serves MFHI/MFLO reads with same-cycle forwarding.
- MADD/MSUB accumulation is split over two cycles (low word, then high word with carry/borrow); the unit drives Busy so the pipeline stalls.

Parameters:
- WIDTH, 32, width of each of HI and LO
- RESET_HI, 0, reset value of HI
- RESET_LO, 0, reset value of LO

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous reset, active-low
- OpValid  input  1  Op/ProdHi/ProdLo/Src are valid this cycle
- Op  input  3  000 NOP, 001 MULT, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110 CLR, 111 reserved (treated as NOP)
- ProdHi  input  WIDTH  upper word of ALU product
- ProdLo  input  WIDTH  lower word of ALU product
- Src  input  WIDTH  rs value for MTHI/MTLO
- Flush  input  1  kill the accepted op and any in-flight accumulate
- ReadSel  input  1  0 = LO, 1 = HI
- ReadData  output  WIDTH  selected register value, forwarded
- HI  output  WIDTH  committed HI
- LO  output  WIDTH  committed LO
- Busy  output  1  unit cannot accept an op this cycle
- AccOverflow  output  1  sticky flag: a 64-bit MADD wrap or MSUB borrow-out occurred

Behaviour:
- Reset (Rst==0 at a rising edge):
  - HI=RESET_HI, LO=RESET_LO, Busy=0, AccOverflow=0.
  - State goes to IDLE and the internal carry register is cleared.
  - Reset has priority over every other input, including mid-accumulate; the partial accumulate is discarded.
- States: IDLE, ACC_HI.
- IDLE, OpValid=1, Flush=0, committed at the next edge:
  - MULT: {HI,LO}={ProdHi,ProdLo}.
  - MTHI: HI=Src; LO unchanged.
  - MTLO: LO=Src; HI unchanged.
  - CLR: HI=0, LO=0; AccOverflow cleared.
  - NOP or 111: no change.
- IDLE, MADD/MSUB:
  - Edge 1: LO=LO±ProdLo; store carry (MADD) or borrow (MSUB) in a 1-bit register; latch ProdHi internally; go to ACC_HI.
  - Busy=1 combinationally while in ACC_HI.
  - Edge 2: HI=HI±latched ProdHi±carry/borrow; if the 64-bit result wrapped, set AccOverflow; return to IDLE.
  - Total latency is 2 edges; back-to-back MADD throughput is one per 2 cycles.
- ACC_HI: OpValid and all operand inputs are ignored. Upstream must hold the next op while Busy=1; the unit never queues ops.
- Flush=1:
  - In IDLE: the op presented that cycle is not committed.
  - In ACC_HI: HI is not updated, LO is restored to its pre-MADD value (held in a shadow register), and the state returns to IDLE the next cycle.
- ReadData forwarding:
  - In IDLE with a valid, unflushed MULT/MTHI/MTLO/CLR this cycle, ReadData returns the value about to be committed for the selected register; otherwise it returns the committed register.
  - In ACC_HI, ReadData returns the committed register. Readers must stall on Busy; reads made during Busy are undefined by contract.
- Arithmetic: all sums and differences are modulo 2^(2*WIDTH); there is no signed saturation. The MSUB borrow propagates from LO to HI.
- HI and LO are driven directly from registers, with no combinational path from inputs. Busy depends only on state.

Test Plan:
- Reset then MULT with ProdHi=0x00000001, ProdLo=0xFFFFFFFF -> next cycle HI=0x00000001, LO=0xFFFFFFFF; same-cycle ReadSel=0 returns 0xFFFFFFFF.
- After the previous case, MADD with ProdHi=0, ProdLo=1 -> cycle 1: Busy=1, LO=0x00000000; cycle 2: HI=0x00000002, Busy=0, AccOverflow=0.
- HI=LO=0, MSUB with ProdHi=0, ProdLo=1 -> HI=LO=0xFFFFFFFF, AccOverflow=1; a subsequent CLR -> HI=LO=0, AccOverflow=0.
- MTHI Src=0xDEADBEEF, then MTLO Src=0x12345678 on the next cycle -> HI=0xDEADBEEF, LO=0x12345678; ReadSel=1 during MTHI returns 0xDEADBEEF.
- MADD start followed by Flush=1 in ACC_HI -> HI/LO return to their pre-MADD values and Busy=0 the next cycle; a MULT presented during Busy is not committed.
- Rst=0 asserted during ACC_HI -> HI=LO=0, Busy=0, state IDLE on that edge.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register unit: commits MULT/MADD/MSUB/MTHI/MTLO/CLR and forwards MFHI/MFLO reads.
// Single-cycle commits, 2-cycle MADD/MSUB; Busy stalls upstream while the high word accumulates.
module hilo_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_HI = '0,
    parameter logic [WIDTH-1:0] RESET_LO = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             OpValid,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] ProdHi,
    input  logic [WIDTH-1:0] ProdLo,
    input  logic [WIDTH-1:0] Src,
    input  logic             Flush,
    input  logic             ReadSel,
    output logic [WIDTH-1:0] ReadData,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             AccOverflow
);

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_MADD = 3'b010;
    localparam logic [2:0] OP_MSUB = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic {IDLE, ACC_HI} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] lo_shadow;
    logic [WIDTH-1:0] prod_hi_q;
    logic             carry_q;
    logic             is_sub;
    logic             acc_ovf;

    logic [WIDTH:0]   lo_sum;
    logic [WIDTH:0]   hi_sum;
    logic             take;

    assign take = (state == IDLE) && OpValid && !Flush;

    // Top bit of each (WIDTH+1)-bit result is the carry (add) or borrow (subtract) out.
    assign lo_sum = (Op == OP_MSUB) ? ({1'b0, lo_q} - {1'b0, ProdLo})
                                    : ({1'b0, lo_q} + {1'b0, ProdLo});
    assign hi_sum = is_sub ? ({1'b0, hi_q} - {1'b0, prod_hi_q} - {{WIDTH{1'b0}}, carry_q})
                           : ({1'b0, hi_q} + {1'b0, prod_hi_q} + {{WIDTH{1'b0}}, carry_q});

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            hi_q      <= RESET_HI;
            lo_q      <= RESET_LO;
            lo_shadow <= '0;
            prod_hi_q <= '0;
            carry_q   <= 1'b0;
            is_sub    <= 1'b0;
            acc_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        case (Op)
                            OP_MULT: begin
                                hi_q <= ProdHi;
                                lo_q <= ProdLo;
                            end
                            OP_MADD, OP_MSUB: begin
                                lo_shadow <= lo_q;
                                lo_q      <= lo_sum[WIDTH-1:0];
                                carry_q   <= lo_sum[WIDTH];
                                prod_hi_q <= ProdHi;
                                is_sub    <= (Op == OP_MSUB);
                                state     <= ACC_HI;
                            end
                            OP_MTHI: hi_q <= Src;
                            OP_MTLO: lo_q <= Src;
                            OP_CLR: begin
                                hi_q    <= '0;
                                lo_q    <= '0;
                                acc_ovf <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ACC_HI: begin
                    state <= IDLE;
                    // A flushed accumulate must leave no trace, so LO rolls back to its shadow.
                    if (Flush) begin
                        lo_q <= lo_shadow;
                    end else begin
                        hi_q <= hi_sum[WIDTH-1:0];
                        if (hi_sum[WIDTH]) begin
                            acc_ovf <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ReadData = ReadSel ? hi_q : lo_q;
        if (take) begin
            case (Op)
                OP_MULT: ReadData = ReadSel ? ProdHi : ProdLo;
                OP_MTHI: ReadData = ReadSel ? Src : lo_q;
                OP_MTLO: ReadData = ReadSel ? hi_q : Src;
                OP_CLR:  ReadData = '0;
                default: ;
            endcase
        end
    end

    assign HI          = hi_q;
    assign LO          = lo_q;
    assign Busy        = (state == ACC_HI);
    assign AccOverflow = acc_ovf;

endmodule
